// File: rtl/grayscale.sv
// RGB-to-grey writer feeding the sobel grey FIFO: grey = floor((R+G+B)/3), per-frame pixel count.
// Latency: pop in cycle t, push in cycle t+2 when the grey FIFO is not full; 1 pixel/clock sustained.
// Backpressure: a full grey FIFO with a word waiting freezes both stages and stops popping.
module grayscale #(
    parameter int IMG_WIDTH  = 720,
    parameter int IMG_HEIGHT = 540
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_empty,
    output logic        in_rd_en,
    input  logic [23:0] in_dout,
    input  logic        grey_out_full,
    output logic        grey_out_wr_en,
    output logic [7:0]  grey_out_din,
    output logic        frame_done
);

    localparam int          FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [18:0] LAST_PIX  = 19'(FRAME_PIX - 1);

    logic        s1_valid;
    logic [9:0]  s1_sum;
    logic        s2_valid;
    logic [7:0]  s2_grey;
    logic [18:0] pixel_cnt;
    logic        stall;

    // Bubbles never stall: only a real word stuck at the output freezes the pipe.
    assign stall          = s2_valid & grey_out_full;
    assign in_rd_en       = !reset & !in_empty & !stall;
    assign grey_out_wr_en = !reset & s2_valid & !grey_out_full;
    assign grey_out_din   = s2_grey;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_sum     <= '0;
            s2_valid   <= 1'b0;
            s2_grey    <= '0;
            pixel_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            if (!stall) begin
                s1_sum   <= 10'(in_dout[23:16]) + 10'(in_dout[15:8]) + 10'(in_dout[7:0]);
                s1_valid <= in_rd_en;
                // 683/2048 is an exact floor(sum/3) for every sum up to 765.
                s2_grey  <= 8'((20'(s1_sum) * 20'd683) >> 11);
                s2_valid <= s1_valid;
            end
            frame_done <= grey_out_wr_en && (pixel_cnt == LAST_PIX);
            if (grey_out_wr_en) begin
                pixel_cnt <= (pixel_cnt == LAST_PIX) ? '0 : pixel_cnt + 19'd1;
            end
        end
    end

endmodule

// File: tb/tb_grayscale.sv
// Bench for grayscale with a 4x3 frame: FWFT source queue, grey scoreboard and frame model.
module tb_grayscale;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int FP = W * H;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_empty;
    logic        in_rd_en;
    logic [23:0] in_dout;
    logic        grey_out_full;
    logic        grey_out_wr_en;
    logic [7:0]  grey_out_din;
    logic        frame_done;

    always #5 clock = ~clock;

    grayscale #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_empty       (in_empty),
        .in_rd_en       (in_rd_en),
        .in_dout        (in_dout),
        .grey_out_full  (grey_out_full),
        .grey_out_wr_en (grey_out_wr_en),
        .grey_out_din   (grey_out_din),
        .frame_done     (frame_done)
    );

    typedef struct {
        int grey;
        int cyc;
    } exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [23:0] src[$];
    exp_t        exp_q[$];
    int          got[$];
    bit          gap, chk_lat, chk_mirror, chk_stall, stall_saved, exp_fd, rd_d1, rd_d2;
    logic [7:0]  stall_din;
    int          cyc, push_cnt, fd_cnt, pops;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int ref_grey(input logic [23:0] p);
        return (int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0])) / 3;
    endfunction

    task automatic drive_inputs();
        in_empty = (src.size() == 0) || gap;
        in_dout  = (src.size() != 0) ? src[0] : 24'h0;
    endtask

    task automatic tick();
        bit         pop, push, fd_next;
        logic [7:0] din;
        exp_t       e;
        @(negedge clock);
        pop  = in_rd_en;
        push = grey_out_wr_en;
        din  = grey_out_din;
        check_eq("frame_done", frame_done, exp_fd);
        if (frame_done) fd_cnt++;
        check_eq("pop_when_empty", pop & in_empty, 0);
        if (reset) begin
            check_eq("rst_rd_en", pop, 0);
            check_eq("rst_wr_en", push, 0);
        end
        if (chk_stall) begin
            check_eq("stall_rd_en", pop, 0);
            if (stall_saved) check_eq("stall_din", din, stall_din);
            else begin
                stall_din   = din;
                stall_saved = 1'b1;
            end
        end
        if (chk_mirror) check_eq("wr_mirror", push, rd_d2);
        if (push) begin
            got.push_back(int'(din));
            if (exp_q.size() == 0) check_eq("unexpected_push", push, 0);
            else begin
                e = exp_q.pop_front();
                check_eq("grey", din, e.grey);
                if (chk_lat) check_eq("latency", cyc - e.cyc, 2);
            end
            push_cnt++;
        end
        fd_next = push && (push_cnt % FP == 0);
        if (pop && src.size() != 0) begin
            exp_q.push_back('{ref_grey(src[0]), cyc});
            pops++;
        end
        rd_d2 = rd_d1;
        rd_d1 = pop;
        @(posedge clock);
        cyc++;
        if (pop && src.size() != 0) void'(src.pop_front());
        if (reset) begin
            exp_q.delete();
            push_cnt = 0;
            exp_fd   = 1'b0;
            rd_d1    = 1'b0;
            rd_d2    = 1'b0;
        end else begin
            exp_fd = fd_next;
        end
        #1;
        drive_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        while ((src.size() != 0 || exp_q.size() != 0) && guard < 3000) begin
            tick();
            guard++;
        end
        check_eq(tag, src.size() + exp_q.size(), 0);
    endtask

    initial begin
        int t1[4];
        int r, g, b, rest;
        t1 = '{60, 255, 0, 171};
        reset = 1'b1; gap = 1'b0; grey_out_full = 1'b0;
        chk_lat = 1'b0; chk_mirror = 1'b0; chk_stall = 1'b0; stall_saved = 1'b0;
        exp_fd = 1'b0; rd_d1 = 1'b0; rd_d2 = 1'b0;
        cyc = 0; push_cnt = 0; fd_cnt = 0; pops = 0;
        drive_inputs();
        @(posedge clock);
        #1;
        do_reset();
        check_eq("rst_din", grey_out_din, 0);
        check_eq("rst_fd", frame_done, 0);
        check_eq("rst_wr", grey_out_wr_en, 0);

        // Test 1: four known pixels, no backpressure.
        chk_lat = 1'b1;
        got.delete();
        pops = 0;
        src = '{{8'd30, 8'd60, 8'd90}, {8'd255, 8'd255, 8'd255}, {8'd0, 8'd0, 8'd1}, {8'd171, 8'd172, 8'd172}};
        drive_inputs();
        repeat (8) tick();
        check_eq("t1_pops", pops, 4);
        check_eq("t1_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check_eq("t1_grey", got[i], t1[i]);

        // Test 2: every sum 0..765.
        got.delete();
        for (int s = 0; s <= 765; s++) begin
            r = (s > 255) ? 255 : s;
            rest = s - r;
            g = (rest > 255) ? 255 : rest;
            b = rest - g;
            src.push_back({8'(r), 8'(g), 8'(b)});
        end
        drive_inputs();
        drain("t2_drain");
        check_eq("t2_count", got.size(), 766);
        if (got.size() == 766) begin
            check_eq("t2_sum515", got[515], 171);
            check_eq("t2_sum764", got[764], 254);
        end

        // Test 3: full held 5 cycles mid-stream.
        got.delete();
        for (int i = 0; i < 20; i++) src.push_back(24'($urandom));
        drive_inputs();
        repeat (4) tick();
        chk_lat = 1'b0;
        grey_out_full = 1'b1;
        chk_stall = 1'b1;
        stall_saved = 1'b0;
        repeat (5) tick();
        chk_stall = 1'b0;
        grey_out_full = 1'b0;
        drain("t3_drain");
        check_eq("t3_count", got.size(), 20);

        // Test 4: in_empty toggles every cycle.
        chk_lat = 1'b1;
        chk_mirror = 1'b1;
        for (int i = 0; i < 20; i++) src.push_back(24'($urandom));
        for (int i = 0; i < 50; i++) begin
            gap = ~gap;
            drive_inputs();
            tick();
        end
        gap = 1'b0;
        drive_inputs();
        chk_mirror = 1'b0;
        drain("t4_drain");

        // Test 5: 25 pixels from a clean frame start.
        do_reset();
        fd_cnt = 0;
        for (int i = 0; i < 25; i++) src.push_back(24'($urandom));
        drive_inputs();
        drain("t5_drain");
        repeat (2) tick();
        check_eq("t5_fd_pulses", fd_cnt, 2);
        check_eq("t5_pushes", push_cnt, 25);

        // Test 6: reset with two pixels in flight.
        do_reset();
        for (int i = 0; i < 30; i++) src.push_back(24'($urandom));
        drive_inputs();
        repeat (3) tick();
        do_reset();
        check_eq("t6_wr_after_rst", grey_out_wr_en, 0);
        fd_cnt = 0;
        check_eq("t6_src_left", src.size(), 27);
        drain("t6_drain");
        repeat (2) tick();
        check_eq("t6_fd_pulses", fd_cnt, 2);
        check_eq("t6_pushes", push_cnt, 27);

        // Random traffic with random gaps and backpressure.
        chk_lat = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if (src.size() < 8 && $urandom_range(0, 3) != 0) src.push_back(24'($urandom));
            gap = ($urandom_range(0, 3) == 0);
            grey_out_full = ($urandom_range(0, 2) == 0);
            drive_inputs();
            tick();
        end
        gap = 1'b0;
        grey_out_full = 1'b0;
        drive_inputs();
        drain("rand_drain");
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
